para_event_logger: RTL and testbench
====================================

PARA_EVENT_LOGGER -- requirements
Module: para_event_logger

Interface
REQ-001 Parameter TS_W, default 16, width of the timestamp counter and of logged timestamps.
REQ-002 Parameter DEPTH, default 8, number of log entries (power of two, >=2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  capture enable; timestamp counter runs regardless.
REQ-006 ai  input  4  observed bus A (driven by the sequential/parallel stimulus stage).
REQ-007 bi  input  4  observed bus B.
REQ-008 out_valid  output  1  log head entry is valid.
REQ-009 out_ready  input  1  consumer accepts head entry.
REQ-010 out_ts  output  TS_W  timestamp of head entry.
REQ-011 out_ai / out_bi  output  4 each  bus values captured in head entry.
REQ-012 out_chg  output  2  {A changed, B changed} flags of head entry.
REQ-013 level  output  $clog2(DEPTH)+1  current entry count.
REQ-014 ovf  output  1  sticky overflow flag.

Function
REQ-015 Timestamp counter ts SHALL increment by 1 every cycle, wrap from 2^TS_W-1 to 0.
REQ-016 Registers ai_prev/bi_prev SHALL load ai/bi every cycle, independent of en.
REQ-017 Change event at edge k: en=1 and (ai!=ai_prev or bi!=bi_prev), both sampled before edge k.
REQ-018 Event SHALL push one entry {ts, ai, bi, chg} using ts value before edge k; chg[1]=(ai!=ai_prev), chg[0]=(bi!=bi_prev).
REQ-019 Simultaneous change on both buses SHALL produce exactly one entry with chg=2'b11, never two.
REQ-020 Latency: event at edge k SHALL make entry visible on outputs (out_valid=1 if log was empty) immediately after edge k.
REQ-021 Log SHALL be FIFO, first-word-fall-through; out_* show oldest entry whenever out_valid=1.
REQ-022 Pop on edge where out_valid&out_ready; out_* are don't-care while out_valid=0.
REQ-023 Full (level=DEPTH) with push and no pop: entry dropped, ovf set to 1, log unchanged.
REQ-024 Full with push and pop in same edge: pop and push both succeed, level stays DEPTH, ovf unchanged.
REQ-025 Empty with push: out_ready ignored that edge, level becomes 1.
REQ-026 ovf SHALL stay 1 until reset.
REQ-027 en deasserted: no pushes; pops continue; prev registers still track.

Reset
REQ-028 rst=1 SHALL immediately clear ts, ai_prev, bi_prev, level, ovf to 0 and force out_valid=0.
REQ-029 Reset mid-operation discards all entries; first edge after release compares against prev=0, so nonzero ai/bi log an event with ts=0.

Configuration
REQ-030 Macro DROP_CNT_EN defined: extra output drop_cnt (8 bits), reset 0, increments per dropped entry, saturates at 255.
REQ-031 DROP_CNT_EN undefined: port and counter absent; behaviour otherwise identical.

Structure
REQ-032 Package para_log_pkg SHALL hold default TS_W/DEPTH constants and typedef log_entry_t {ts, ai, bi, chg}.
REQ-033 Storage SHALL be sub-module evt_fifo (synchronous FWFT FIFO, level and full/empty), instantiated once.

Verification
REQ-034 Reset release, ai=0,bi=0, then ai=5 at cycle 5, bi=8 at cycle 10 -> two entries, ts 5/10, chg 2'b10 then 2'b01.
REQ-035 ai=5 and bi=8 in same cycle 5 -> single entry ts=5, chg=2'b11, level=1.
REQ-036 out_ready=0, 9 changes with DEPTH=8 -> level=8, ovf=1, 9th dropped, drop_cnt=1 if DROP_CNT_EN.
REQ-037 Full log, out_ready=1 and change on same edge -> level stays 8, ovf stays 0, head advances.
REQ-038 TS_W=4, event at cycle 17 -> out_ts=1 (wrap).
REQ-039 rst pulsed mid-burst with 3 entries held, ai=3 at release -> level 0 during reset, then one entry ts=0, out_ai=3.

Source files
------------

// File: rtl/para_log_pkg.sv
// Shared constants and log entry layout for para_event_logger and its storage.
// Logged timestamps are zero-extended to TS_MAX_W, so TS_W may not exceed it.
package para_log_pkg;
   localparam int TS_W_DEF  = 16;
   localparam int DEPTH_DEF = 8;
   localparam int TS_MAX_W  = 32;

   typedef struct packed {
      logic [TS_MAX_W-1:0] ts;
      logic [3:0]          ai;
      logic [3:0]          bi;
      logic [1:0]          chg;
   } log_entry_t;

   localparam int ENTRY_W = $bits(log_entry_t);
endpackage

// File: rtl/evt_fifo.sv
// Generic synchronous first-word-fall-through FIFO with occupancy count.
// Latency: a push is visible on pop_dat right after its edge. Backpressure: when full, a push is accepted only alongside a pop.
// DEPTH must be a power of two so the pointers wrap without a compare.
module evt_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               push_dat,
   input  logic                       pop,
   output logic [W-1:0]               pop_dat,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          push_ok;
   logic          pop_ok;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign pop_dat = mem[rd_ptr];
   assign level   = cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_dat;
   end
endmodule

// File: rtl/para_event_logger.sv
// Timestamped change logger for buses ai/bi; optional drop counter under DROP_CNT_EN.
// Latency: an event at an edge is at the log head right after that edge. Backpressure: out_valid/out_ready; a full log drops new events and sets ovf.
module para_event_logger
   import para_log_pkg::*;
#(
   parameter int TS_W  = TS_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [3:0]              ai,
   input  logic [3:0]              bi,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [TS_W-1:0]         out_ts,
   output logic [3:0]              out_ai,
   output logic [3:0]              out_bi,
   output logic [1:0]              out_chg,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    ovf
`ifdef DROP_CNT_EN
   ,
   output logic [7:0]              drop_cnt
`endif
);
   logic [TS_W-1:0] ts;
   logic [3:0]      ai_prev;
   logic [3:0]      bi_prev;
   logic [1:0]      chg;
   logic            evt;
   logic            pop;
   logic            empty;
   logic            full;
   logic            drop;
   log_entry_t      wr_ent;
   log_entry_t      rd_ent;
   logic            unused_ts_hi;

   // Both buses fold into one entry, so a simultaneous change never logs twice.
   assign chg    = {ai != ai_prev, bi != bi_prev};
   assign evt    = en & (|chg);
   assign pop    = out_valid & out_ready;
   assign drop   = evt & full & ~pop;
   assign wr_ent = '{ts: TS_MAX_W'(ts), ai: ai, bi: bi, chg: chg};

   evt_fifo #(
      .W     (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (evt),
      .push_dat (wr_ent),
      .pop      (pop),
      .pop_dat  (rd_ent),
      .empty    (empty),
      .full     (full),
      .level    (level)
   );

   assign out_valid    = ~empty;
   assign out_ts       = rd_ent.ts[TS_W-1:0];
   assign out_ai       = rd_ent.ai;
   assign out_bi       = rd_ent.bi;
   assign out_chg      = rd_ent.chg;
   // Bits above TS_W are always zero; reducing the whole field keeps it consumed.
   assign unused_ts_hi = |rd_ent.ts;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts      <= '0;
         ai_prev <= '0;
         bi_prev <= '0;
         ovf     <= 1'b0;
      end else begin
         ts      <= ts + TS_W'(1);
         ai_prev <= ai;
         bi_prev <= bi;
         if (drop) ovf <= 1'b1;
      end
   end

`ifdef DROP_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (drop && drop_cnt != 8'hFF) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end
`endif
endmodule

// File: tb/tb_para_event_logger.sv
// Bench for para_event_logger: queue-based reference model checked every cycle, plus directed literal scenarios.
module tb_para_event_logger;
   localparam int DEPTH = 8;

   typedef struct {
      int         ts;
      logic [3:0] ai;
      logic [3:0] bi;
      logic [1:0] chg;
   } m_ent_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [3:0] ai = '0;
   logic [3:0] bi = '0;
   logic       out_ready = 1'b0;

   logic        out_valid, ovf, w_out_valid, w_ovf;
   logic [15:0] out_ts;
   logic [3:0]  w_out_ts;
   logic [3:0]  out_ai, out_bi, w_out_ai, w_out_bi;
   logic [1:0]  out_chg, w_out_chg;
   logic [3:0]  level, w_level;
`ifdef DROP_CNT_EN
   logic [7:0]  drop_cnt, w_drop_cnt;
`endif

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   m_ent_t q[$];
   int     m_ts = 0;
   logic [3:0] m_ai_prev = '0;
   logic [3:0] m_bi_prev = '0;
   bit     m_ovf = 1'b0;
   int     m_drops = 0;

   para_event_logger #(.TS_W(16), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst(rst), .en(en), .ai(ai), .bi(bi),
      .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts),
      .out_ai(out_ai), .out_bi(out_bi), .out_chg(out_chg),
      .level(level), .ovf(ovf)
`ifdef DROP_CNT_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   para_event_logger #(.TS_W(4), .DEPTH(DEPTH)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .ai(ai), .bi(bi),
      .out_valid(w_out_valid), .out_ready(out_ready), .out_ts(w_out_ts),
      .out_ai(w_out_ai), .out_bi(w_out_bi), .out_chg(w_out_chg),
      .level(w_level), .ovf(w_ovf)
`ifdef DROP_CNT_EN
      , .drop_cnt(w_drop_cnt)
`endif
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the log is a plain queue of entries; ts is the cycle count since reset.
   initial forever begin : model
      bit ev, pp;
      m_ent_t e, dropped;
      @(posedge clk or posedge rst);
      if (rst) begin
         q.delete();
         m_ts = 0; m_ai_prev = '0; m_bi_prev = '0; m_ovf = 1'b0; m_drops = 0;
      end else begin
         ev = en && (ai != m_ai_prev || bi != m_bi_prev);
         pp = (q.size() > 0) && out_ready;
         if (pp) dropped = q.pop_front();
         if (ev) begin
            if (q.size() < DEPTH) begin
               e.ts = m_ts; e.ai = ai; e.bi = bi;
               e.chg = {ai != m_ai_prev, bi != m_bi_prev};
               q.push_back(e);
            end else begin
               m_ovf = 1'b1;
               if (m_drops < 255) m_drops++;
            end
         end
         m_ts = (m_ts + 1) % 65536;
         m_ai_prev = ai;
         m_bi_prev = bi;
      end
   end

   initial forever begin : compare
      @(negedge clk);
      if (chk_on) begin
         chk("valid", out_valid, q.size() != 0);
         chk("level", level, q.size());
         chk("ovf", ovf, m_ovf);
         chk("w_valid", w_out_valid, q.size() != 0);
         chk("w_level", w_level, q.size());
         chk("w_ovf", w_ovf, m_ovf);
`ifdef DROP_CNT_EN
         chk("drop_cnt", drop_cnt, m_drops);
         chk("w_drop_cnt", w_drop_cnt, m_drops);
`endif
         if (q.size() != 0) begin
            chk("head_ts", out_ts, q[0].ts);
            chk("head_ai", out_ai, q[0].ai);
            chk("head_bi", out_bi, q[0].bi);
            chk("head_chg", out_chg, q[0].chg);
            chk("w_head_ts", w_out_ts, q[0].ts % 16);
            chk("w_head_ai", w_out_ai, q[0].ai);
            chk("w_head_chg", w_out_chg, q[0].chg);
         end
      end
   end

   // Inputs change 2 time units after a falling edge, clear of both sampling points.
   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1; ai = '0; bi = '0; out_ready = 1'b0; en = 1'b1;
      edges(2);
      rst = 1'b0;
   endtask

   initial begin : stim
      int rp;
      edges(1);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_level", level, 0);
      chk("rst_ovf", ovf, 1'b0);
      chk_on = 1'b1;

      // Separate changes on A then B; then timestamp wrap on the 4-bit instance.
      do_reset();
      edges(5); ai = 4'd5;
      edges(5); bi = 4'd8;
      edges(1);
      chk("sep_level", level, 2);
      chk("sep_ts0", out_ts, 5);
      chk("sep_chg0", out_chg, 2'b10);
      out_ready = 1'b1; edges(1); out_ready = 1'b0;
      chk("sep_ts1", out_ts, 10);
      chk("sep_chg1", out_chg, 2'b01);
      chk("sep_bi1", out_bi, 4'd8);
      out_ready = 1'b1; edges(1); out_ready = 1'b0;
      chk("sep_drained", out_valid, 1'b0);
      edges(4); ai = 4'd7;
      edges(1);
      chk("wrap_ts16", out_ts, 17);
      chk("wrap_ts4", w_out_ts, 1);

      // Simultaneous change on both buses.
      do_reset();
      edges(5); ai = 4'd5; bi = 4'd8;
      edges(1);
      chk("both_level", level, 1);
      chk("both_ts", out_ts, 5);
      chk("both_chg", out_chg, 2'b11);

      // Nine changes with no consumer: one dropped.
      do_reset();
      for (int i = 0; i < 9; i++) begin ai = 4'(i + 1); edges(1); end
      chk("ovf_level", level, 8);
      chk("ovf_flag", ovf, 1'b1);
      chk("ovf_head_ts", out_ts, 0);
`ifdef DROP_CNT_EN
      chk("ovf_drop_cnt", drop_cnt, 1);
`endif
      out_ready = 1'b1; edges(8); out_ready = 1'b0;
      chk("ovf_sticky", ovf, 1'b1);

      // Full log with simultaneous pop and push.
      do_reset();
      for (int i = 0; i < 8; i++) begin ai = 4'(i + 1); edges(1); end
      out_ready = 1'b1; ai = 4'd9; edges(1); out_ready = 1'b0;
      chk("fullpp_level", level, 8);
      chk("fullpp_ovf", ovf, 1'b0);
      chk("fullpp_head_ts", out_ts, 1);

      // Reset pulsed with entries held.
      do_reset();
      for (int i = 0; i < 3; i++) begin ai = 4'(i + 1); edges(1); end
      chk("mid_level_pre", level, 3);
      rst = 1'b1; #1;
      chk("mid_level_rst", level, 0);
      chk("mid_valid_rst", out_valid, 1'b0);
      ai = 4'd3; edges(1);
      rst = 1'b0; edges(1);
      chk("mid_level_post", level, 1);
      chk("mid_ts_post", out_ts, 0);
      chk("mid_ai_post", out_ai, 4'd3);

      // Randomized traffic with varying consumer rate and rare resets.
      do_reset();
      rp = 2;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) rp = $urandom_range(0, 4);
         rst = ($urandom_range(0, 499) == 0);
         en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 2) == 0) ai = 4'($urandom);
         if ($urandom_range(0, 2) == 0) bi = 4'($urandom);
         out_ready = ($urandom_range(0, 3) < rp);
         edges(1);
      end
      rst = 1'b0;
      edges(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
